// File: rtl/reg_file_wb_if.sv
// rtl/reg_file_wb_if.sv - operand/result/write-back bus between ALU, control unit and reg_file_wb
interface reg_file_wb_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3
);
  logic [DATA_W-1:0] IN;
  logic [ADDR_W-1:0] INADDRESS;
  logic              WRITE;
  logic [ADDR_W-1:0] OUT1ADDRESS;
  logic [ADDR_W-1:0] OUT2ADDRESS;
  logic              BUSYWAIT;
  logic [DATA_W-1:0] OUT1;
  logic [DATA_W-1:0] OUT2;
  logic              STALL;
  logic              PENDING;

  modport master (
    output IN, INADDRESS, WRITE, OUT1ADDRESS, OUT2ADDRESS, BUSYWAIT,
    input  OUT1, OUT2, STALL, PENDING
  );

  modport slave (
    input  IN, INADDRESS, WRITE, OUT1ADDRESS, OUT2ADDRESS, BUSYWAIT,
    output OUT1, OUT2, STALL, PENDING
  );
endinterface

// File: rtl/reg_file_wb.sv
// rtl/reg_file_wb.sv - 8x8 register file with one-entry write-back buffer held off by BUSYWAIT
// Optional read bypass of the buffered write: define REG_FILE_BYPASS_EN.
module reg_file_wb #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3
) (
  input  logic          CLK,
  input  logic          RESET_N,
  reg_file_wb_if.slave  bus
);
  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic {EMPTY = 1'b0, HELD = 1'b1} state_e;

  state_e            state_q;
  logic [ADDR_W-1:0] wb_addr_q;
  logic [DATA_W-1:0] wb_data_q;
  logic [DATA_W-1:0] regs_q [DEPTH];

  logic wb_valid;
  logic commit;
  logic hazard;
  logic stall;
  logic load;

  assign wb_valid = (state_q == HELD);
  assign commit   = wb_valid & ~bus.BUSYWAIT;

`ifdef REG_FILE_BYPASS_EN
  assign hazard   = 1'b0;
  assign bus.OUT1 = (wb_valid && (wb_addr_q == bus.OUT1ADDRESS)) ? wb_data_q
                                                                 : regs_q[bus.OUT1ADDRESS];
  assign bus.OUT2 = (wb_valid && (wb_addr_q == bus.OUT2ADDRESS)) ? wb_data_q
                                                                 : regs_q[bus.OUT2ADDRESS];
`else
  // Without forwarding, reading the buffered address would return stale data.
  assign hazard   = wb_valid & ((wb_addr_q == bus.OUT1ADDRESS) |
                                (wb_addr_q == bus.OUT2ADDRESS));
  assign bus.OUT1 = regs_q[bus.OUT1ADDRESS];
  assign bus.OUT2 = regs_q[bus.OUT2ADDRESS];
`endif

  assign stall       = (wb_valid & bus.BUSYWAIT) | hazard;
  assign load        = bus.WRITE & ~stall;
  assign bus.STALL   = stall;
  assign bus.PENDING = wb_valid;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q   <= EMPTY;
      wb_addr_q <= '0;
      wb_data_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      if (commit) begin
        regs_q[wb_addr_q] <= wb_data_q;
      end
      case (state_q)
        EMPTY: begin
          if (load) begin
            state_q   <= HELD;
            wb_addr_q <= bus.INADDRESS;
            wb_data_q <= bus.IN;
          end
        end
        HELD: begin
          // A load here implies the old entry commits this same edge.
          if (load) begin
            wb_addr_q <= bus.INADDRESS;
            wb_data_q <= bus.IN;
          end else if (commit) begin
            state_q <= EMPTY;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_reg_file_wb.sv
// tb/tb_reg_file_wb.sv - self-checking bench for reg_file_wb (optionally with REG_FILE_BYPASS_EN)
module tb_reg_file_wb;
  typedef struct packed {
    logic [2:0] addr;
    logic [7:0] data;
  } wr_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int failures = 0;
  wr_t sb[$];
  logic [7:0] model [8];

  reg_file_wb_if #(.DATA_W(8), .ADDR_W(3)) bus ();

  reg_file_wb #(.DATA_W(8), .ADDR_W(3)) dut (
    .CLK     (clk),
    .RESET_N (rst_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

`ifdef REG_FILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  task automatic drive_write(input logic [2:0] a, input logic [7:0] d);
    bus.WRITE = 1'b1;
    bus.INADDRESS = a;
    bus.IN = d;
    sb.push_back('{addr: a, data: d});
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b1;
    bus.BUSYWAIT = 1'b1;
    bus.OUT1ADDRESS = 3'd6;
    bus.OUT2ADDRESS = 3'd6;
    bus.WRITE = 1'b1;
    bus.INADDRESS = 3'd6;
    bus.IN = 8'h77;
    @(negedge clk);
    bus.WRITE = 1'b0;
    #1;
    checks++;
    if (bus.PENDING !== 1'b1) begin
      failures++;
      $display("FAIL reset_preload_pending got=%0b exp=1", bus.PENDING);
    end
    checks++;
    if (bus.STALL !== 1'b1) begin
      failures++;
      $display("FAIL reset_preload_stall got=%0b exp=1", bus.STALL);
    end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (bus.OUT1 !== 8'h00) begin
      failures++;
      $display("FAIL reset_async_out1 got=%h exp=00", bus.OUT1);
    end
    checks++;
    if (bus.OUT2 !== 8'h00) begin
      failures++;
      $display("FAIL reset_async_out2 got=%h exp=00", bus.OUT2);
    end
    checks++;
    if (bus.STALL !== 1'b0) begin
      failures++;
      $display("FAIL reset_async_stall got=%0b exp=0", bus.STALL);
    end
    checks++;
    if (bus.PENDING !== 1'b0) begin
      failures++;
      $display("FAIL reset_async_pending got=%0b exp=0", bus.PENDING);
    end
    @(negedge clk);
    rst_n = 1'b1;
    bus.BUSYWAIT = 1'b0;
    repeat (2) @(negedge clk);
    for (int a = 0; a < 4; a++) begin
      bus.OUT1ADDRESS = 3'(a);
      bus.OUT2ADDRESS = 3'(a + 4);
      #1;
      checks++;
      if (bus.OUT1 !== 8'h00) begin
        failures++;
        $display("FAIL reset_read_r%0d got=%h exp=00", a, bus.OUT1);
      end
      checks++;
      if (bus.OUT2 !== 8'h00) begin
        failures++;
        $display("FAIL reset_read_r%0d got=%h exp=00", a + 4, bus.OUT2);
      end
    end
  endtask

  task automatic test_basic();
    wr_t e;
    @(negedge clk);
    bus.OUT1ADDRESS = 3'd0;
    bus.OUT2ADDRESS = 3'd0;
    drive_write(3'd1, 8'h05);
    @(negedge clk);
    bus.WRITE = 1'b0;
    #1;
    checks++;
    if (bus.PENDING !== 1'b1) begin
      failures++;
      $display("FAIL basic_pending got=%0b exp=1", bus.PENDING);
    end
    checks++;
    if (bus.STALL !== 1'b0) begin
      failures++;
      $display("FAIL basic_stall got=%0b exp=0", bus.STALL);
    end
    @(negedge clk);
    bus.OUT1ADDRESS = 3'd1;
    bus.OUT2ADDRESS = 3'd2;
    #1;
    e = sb.pop_front();
    model[e.addr] = e.data;
    checks++;
    if (bus.OUT1 !== e.data) begin
      failures++;
      $display("FAIL basic_out1 got=%h exp=%h", bus.OUT1, e.data);
    end
    checks++;
    if (bus.OUT2 !== model[2]) begin
      failures++;
      $display("FAIL basic_out2 got=%h exp=%h", bus.OUT2, model[2]);
    end
    checks++;
    if (bus.PENDING !== 1'b0) begin
      failures++;
      $display("FAIL basic_drained got=%0b exp=0", bus.PENDING);
    end
  endtask

  task automatic test_busywait();
    wr_t e;
    logic [7:0] hold_exp;
    @(negedge clk);
    bus.OUT1ADDRESS = 3'd0;
    bus.OUT2ADDRESS = 3'd0;
    drive_write(3'd2, 8'h0A);
    @(negedge clk);
    bus.BUSYWAIT = 1'b1;
    bus.WRITE = 1'b1;
    bus.INADDRESS = 3'd3;
    bus.IN = 8'h04;
    bus.OUT2ADDRESS = 3'd2;
    hold_exp = BYP ? 8'h0A : model[2];
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++;
      if (bus.STALL !== 1'b1) begin
        failures++;
        $display("FAIL busy_stall_%0d got=%0b exp=1", k, bus.STALL);
      end
      checks++;
      if (bus.PENDING !== 1'b1) begin
        failures++;
        $display("FAIL busy_pending_%0d got=%0b exp=1", k, bus.PENDING);
      end
      checks++;
      if (bus.OUT2 !== hold_exp) begin
        failures++;
        $display("FAIL busy_r2_%0d got=%h exp=%h", k, bus.OUT2, hold_exp);
      end
      @(negedge clk);
    end
    bus.OUT2ADDRESS = 3'd0;
    bus.BUSYWAIT = 1'b0;
    #1;
    checks++;
    if (bus.STALL !== 1'b0) begin
      failures++;
      $display("FAIL busy_release_stall got=%0b exp=0", bus.STALL);
    end
    sb.push_back('{addr: 3'd3, data: 8'h04});
    @(negedge clk);
    bus.WRITE = 1'b0;
    bus.OUT1ADDRESS = 3'd2;
    #1;
    e = sb.pop_front();
    model[e.addr] = e.data;
    checks++;
    if (bus.OUT1 !== e.data) begin
      failures++;
      $display("FAIL busy_r2_commit got=%h exp=%h", bus.OUT1, e.data);
    end
    checks++;
    if (bus.PENDING !== 1'b1) begin
      failures++;
      $display("FAIL busy_r3_accepted got=%0b exp=1", bus.PENDING);
    end
    @(negedge clk);
    bus.OUT1ADDRESS = 3'd3;
    #1;
    e = sb.pop_front();
    model[e.addr] = e.data;
    checks++;
    if (bus.OUT1 !== e.data) begin
      failures++;
      $display("FAIL busy_r3_commit got=%h exp=%h", bus.OUT1, e.data);
    end
  endtask

  task automatic test_back_to_back();
    wr_t e;
    logic [7:0] mid_exp;
    @(negedge clk);
    bus.OUT1ADDRESS = 3'd0;
    bus.OUT2ADDRESS = 3'd0;
    drive_write(3'd4, 8'hA0);
    @(negedge clk);
    #1;
    checks++;
    if (bus.STALL !== 1'b0) begin
      failures++;
      $display("FAIL b2b_stall got=%0b exp=0", bus.STALL);
    end
    drive_write(3'd4, 8'hF0);
    @(negedge clk);
    bus.WRITE = 1'b0;
    bus.OUT1ADDRESS = 3'd4;
    #1;
    e = sb.pop_front();
    model[e.addr] = e.data;
    mid_exp = BYP ? sb[0].data : e.data;
    checks++;
    if (bus.OUT1 !== mid_exp) begin
      failures++;
      $display("FAIL b2b_mid_read got=%h exp=%h", bus.OUT1, mid_exp);
    end
    @(negedge clk);
    #1;
    e = sb.pop_front();
    model[e.addr] = e.data;
    checks++;
    if (bus.OUT1 !== e.data) begin
      failures++;
      $display("FAIL b2b_final got=%h exp=%h", bus.OUT1, e.data);
    end
  endtask

  task automatic test_hazard();
    wr_t e;
    logic [7:0] old_exp;
    @(negedge clk);
    bus.OUT1ADDRESS = 3'd5;
    bus.OUT2ADDRESS = 3'd0;
    old_exp = model[5];
    drive_write(3'd5, 8'h0A);
    @(negedge clk);
    bus.WRITE = 1'b0;
    #1;
    checks++;
    if (bus.STALL !== !BYP) begin
      failures++;
      $display("FAIL hazard_stall got=%0b exp=%0b", bus.STALL, !BYP);
    end
    checks++;
    if (bus.OUT1 !== (BYP ? sb[0].data : old_exp)) begin
      failures++;
      $display("FAIL hazard_read got=%h exp=%h", bus.OUT1, BYP ? sb[0].data : old_exp);
    end
    @(negedge clk);
    #1;
    e = sb.pop_front();
    model[e.addr] = e.data;
    checks++;
    if (bus.STALL !== 1'b0) begin
      failures++;
      $display("FAIL hazard_clear_stall got=%0b exp=0", bus.STALL);
    end
    checks++;
    if (bus.OUT1 !== e.data) begin
      failures++;
      $display("FAIL hazard_commit got=%h exp=%h", bus.OUT1, e.data);
    end
  endtask

  task automatic test_boundary();
    wr_t e;
    @(negedge clk);
    bus.OUT1ADDRESS = 3'd1;
    bus.OUT2ADDRESS = 3'd2;
    drive_write(3'd0, 8'h11);
    @(negedge clk);
    drive_write(3'd7, 8'hEE);
    @(negedge clk);
    bus.WRITE = 1'b0;
    bus.OUT1ADDRESS = 3'd0;
    #1;
    e = sb.pop_front();
    model[e.addr] = e.data;
    checks++;
    if (bus.OUT1 !== e.data) begin
      failures++;
      $display("FAIL bound_r0 got=%h exp=%h", bus.OUT1, e.data);
    end
    @(negedge clk);
    bus.OUT2ADDRESS = 3'd7;
    #1;
    e = sb.pop_front();
    model[e.addr] = e.data;
    checks++;
    if (bus.OUT2 !== e.data) begin
      failures++;
      $display("FAIL bound_r7 got=%h exp=%h", bus.OUT2, e.data);
    end
    checks++;
    if (bus.OUT1 !== model[0]) begin
      failures++;
      $display("FAIL bound_r0_kept got=%h exp=%h", bus.OUT1, model[0]);
    end
  endtask

  initial begin
    for (int i = 0; i < 8; i++) model[i] = 8'h00;
    bus.IN = 8'h00;
    bus.INADDRESS = 3'd0;
    bus.WRITE = 1'b0;
    bus.OUT1ADDRESS = 3'd0;
    bus.OUT2ADDRESS = 3'd0;
    bus.BUSYWAIT = 1'b0;
    test_reset();
    test_basic();
    test_busywait();
    test_back_to_back();
    test_hazard();
    test_boundary();
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain got=%0d exp=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
